i2c_codec_target: RTL



---
 rtl/i2c_codec_target.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_codec_target.sv
// i2c_codec_target
// Write-only I2C target that stands in for the audio codec control port.
// SCL/SDA are oversampled on CLOCK_50. The block accepts 3-byte writes
// {dev addr + W, {reg[6:0], data[8]}, data[7:0]} into a 9-bit register file.
//
// Ports:
//   CLOCK_50     system clock
//   reset        synchronous, active-high
//   I2C_SCLK     bus clock from the master
//   I2C_SDAT     bus data; this block only drives 1'b0 or releases (1'bz)
//   reg_file     flattened register file, reg n at [9n+8:9n]
//   wr_valid     one-cycle pulse per completed register write
//   wr_addr      register address of the last write (held)
//   wr_data      data of the last write (held)
//   addr_err     one-cycle pulse for a write to an unmapped address
//   codec_active bit 0 of reg 9
//   busy         FSM not in IDLE
//   write_count  completed writes, saturating at 255
//
// Build option: define I2C_GLITCH_FILTER_EN to add a 3-sample majority
// filter behind each synchronizer. This rejects pulses of up to 2 cycles
// and adds 3 cycles of latency.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 16,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  I2C_SCLK,
  inout  wire                   I2C_SDAT,
  output logic [NUM_REGS*9-1:0] reg_file,
  output logic                  wr_valid,
  output logic [6:0]            wr_addr,
  output logic [8:0]            wr_data,
  output logic                  addr_err,
  output logic                  codec_active,
  output logic                  busy,
  output logic [7:0]            write_count
);
  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK_1, ST_BYTE2, ST_ACK_2, ST_IGNORE
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_r, state_nx;
  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_s, sda_s, scl_prev_r, sda_prev_r;
  logic       scl_rise_s, scl_fall_s, start_det_s, stop_det_s, rx_state_s;
  logic       sda_low_r, sda_low_nx, commit_s, byte_done_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r, byte1_r;
  logic [6:0] cmt_addr_s;
  logic [8:0] cmt_data_s;
  logic [8:0] regs_r [NUM_REGS];

  // Two-flop synchronizers; reset to the idle-bus level so no false edge follows reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], I2C_SCLK};
      sda_sync_r <= {sda_sync_r[0], I2C_SDAT};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r, sda_hist_r;
  logic       scl_filt_r, sda_filt_r;

  // Majority filter: output follows only after 3 equal consecutive synchronized samples
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[0], sda_sync_r[1]};
      if ({scl_hist_r, scl_sync_r[1]} == 3'b111)      scl_filt_r <= 1'b1;
      else if ({scl_hist_r, scl_sync_r[1]} == 3'b000) scl_filt_r <= 1'b0;
      else                                            scl_filt_r <= scl_filt_r;
      if ({sda_hist_r, sda_sync_r[1]} == 3'b111)      sda_filt_r <= 1'b1;
      else if ({sda_hist_r, sda_sync_r[1]} == 3'b000) sda_filt_r <= 1'b0;
      else                                            sda_filt_r <= sda_filt_r;
    end
  end

  assign scl_s = scl_filt_r;
  assign sda_s = sda_filt_r;
`else
  assign scl_s = scl_sync_r[1];
  assign sda_s = sda_sync_r[1];
`endif

  // Previous-sample registers for edge detection
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_rise_s  = scl_s & ~scl_prev_r;
  assign scl_fall_s  = ~scl_s & scl_prev_r;
  // START/STOP need SCL high on both samples so a data change at an SCL edge never qualifies
  assign start_det_s = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_det_s  = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign rx_state_s  = (state_r == ST_ADDR) | (state_r == ST_BYTE1) | (state_r == ST_BYTE2);
  assign cmt_addr_s  = byte1_r[7:1];
  assign cmt_data_s  = {byte1_r[0], shift_r};

  // Next-state, ACK drive and commit strobe
  always_comb begin
    state_nx   = state_r;
    sda_low_nx = sda_low_r;
    commit_s   = 1'b0;
    if (stop_det_s) begin
      state_nx   = ST_IDLE;
      sda_low_nx = 1'b0;
    end else if (start_det_s) begin
      state_nx   = ST_ADDR;
      sda_low_nx = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: state_nx = ST_IDLE;
        ST_ADDR: begin
          if (scl_fall_s && byte_done_r) begin
            if (shift_r == {DEV_ADDR, 1'b0}) begin
              state_nx   = ST_ACK_A;
              sda_low_nx = 1'b1;
            end else begin
              state_nx = ST_IGNORE;
            end
          end else begin
            state_nx = ST_ADDR;
          end
        end
        ST_BYTE1, ST_BYTE2: begin
          if (scl_fall_s && byte_done_r) begin
            state_nx   = (state_r == ST_BYTE1) ? ST_ACK_1 : ST_ACK_2;
            sda_low_nx = 1'b1;
          end else begin
            state_nx = state_r;
          end
        end
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          // The falling edge after the 9th clock ends the ACK
          if (scl_fall_s) begin
            sda_low_nx = 1'b0;
            if (state_r == ST_ACK_A)      state_nx = ST_BYTE1;
            else if (state_r == ST_ACK_1) state_nx = ST_BYTE2;
            else begin
              state_nx = ST_IGNORE;
              commit_s = 1'b1;
            end
          end else begin
            state_nx = state_r;
          end
        end
        ST_IGNORE: state_nx = ST_IGNORE;
        default: begin
          state_nx   = ST_IDLE;
          sda_low_nx = 1'b0;
        end
      endcase
    end
  end

  // State register, SDA pull-down and busy flag
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      sda_low_r <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_nx;
      sda_low_r <= sda_low_nx;
      busy      <= (state_nx != ST_IDLE);
    end
  end

  // Bit capture: MSB-first shift on SCL rise; counter restarts on any state change or START/STOP
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      shift_r     <= 8'd0;
      byte1_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      byte_done_r <= 1'b0;
    end else begin
      if (start_det_s || stop_det_s || (state_nx != state_r)) begin
        bit_cnt_r   <= 3'd0;
        byte_done_r <= 1'b0;
      end else if (scl_rise_s && rx_state_s && !byte_done_r) begin
        shift_r     <= {shift_r[6:0], sda_s};
        bit_cnt_r   <= bit_cnt_r + 3'd1;
        byte_done_r <= (bit_cnt_r == 3'd7);
      end
      if ((state_r == ST_BYTE1) && (state_nx == ST_ACK_1)) byte1_r <= shift_r;
    end
  end

  // Register file update and write reporting; RESET_REG wins over a normal write
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 9'd0;
      wr_valid    <= 1'b0;
      wr_addr     <= 7'd0;
      wr_data     <= 9'd0;
      addr_err    <= 1'b0;
      write_count <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      addr_err <= 1'b0;
      if (commit_s) begin
        if (cmt_addr_s == RESET_REG) begin
          for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 9'd0;
          wr_valid    <= 1'b1;
          wr_addr     <= cmt_addr_s;
          wr_data     <= cmt_data_s;
          write_count <= sat_inc(write_count);
        end else if ({1'b0, cmt_addr_s} < NUM_REGS_W) begin
          regs_r[cmt_addr_s[AW-1:0]] <= cmt_data_s;
          wr_valid    <= 1'b1;
          wr_addr     <= cmt_addr_s;
          wr_data     <= cmt_data_s;
          write_count <= sat_inc(write_count);
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_file[9*g +: 9] = regs_r[g];
  end

  if (NUM_REGS > 9) begin : g_active
    assign codec_active = regs_r[9][0];
  end else begin : g_no_active
    assign codec_active = 1'b0;
  end

  assign I2C_SDAT = sda_low_r ? 1'b0 : 1'bz;

endmodule
